oam_dma_master: RTL and testbench

//  CPU-bus initiator for sprite OAM DMA. Snoops CPU writes to $4014 and latches the source page.

---
 rtl/oam_dma_master_pkg.sv | 29 ++
 rtl/oam_dma_master.sv | 148 ++++++++++++++
 tb/tb_oam_dma_master.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_master_pkg.sv
// Shared constants and FSM state encoding for the sprite OAM DMA initiator.
// The ALIGN state only becomes reachable when OAM_DMA_ALIGN_EN is defined.
package oam_dma_master_pkg;

  localparam logic [15:0] DEF_TRIG_ADDR = 16'h4014;
  localparam logic [15:0] DEF_OAMDATA   = 16'h2004;
  localparam int unsigned XFER_LEN      = 256;
  localparam int unsigned IDX_W         = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

  localparam logic BUS_WN_WRITE = 1'b0;
  localparam logic BUS_WN_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } dma_state_e;

  function automatic logic is_trig_write(input logic        wn,
                                         input logic [15:0] addr,
                                         input logic [15:0] trig);
    return (wn == BUS_WN_WRITE) && (addr == trig);
  endfunction

endpackage

// File: rtl/oam_dma_master.sv
// Sprite OAM DMA bus master: snoops the $4014 write, halts the CPU and copies a
// 256-byte page to $2004. Define OAM_DMA_ALIGN_EN for the odd-cycle alignment stall.
module oam_dma_master
  import oam_dma_master_pkg::*;
#(
  parameter logic [15:0] TRIG_ADDR = DEF_TRIG_ADDR,
  parameter logic [15:0] OAMDATA   = DEF_OAMDATA
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_cpu_ce,
  input  logic [15:0] i_bus_addr,
  input  logic [7:0]  i_bus_wdata,
  input  logic        i_bus_wn,
  input  logic [7:0]  i_bus_rdata,
  output logic        o_cpu_halt,
  output logic        o_dma_own,
  output logic [15:0] o_dma_addr,
  output logic [7:0]  o_dma_wdata,
  output logic        o_dma_wn
);

  dma_state_e       state_q, state_d;
  logic [7:0]       page_q, page_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       latch_q, latch_d;
  logic             halt_q, halt_d;
  logic             own_q, own_d;
  logic [15:0]      addr_q, addr_d;
  logic             wn_q, wn_d;
`ifdef OAM_DMA_ALIGN_EN
  logic             parity_q, parity_d;
`endif

  // Bus outputs are registered and set on entry to the state they belong to,
  // so they are valid for the whole CPU cycle that state occupies.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    latch_d = latch_q;
    halt_d  = halt_q;
    own_d   = own_q;
    addr_d  = addr_q;
    wn_d    = wn_q;
`ifdef OAM_DMA_ALIGN_EN
    parity_d = parity_q;
`endif
    if (i_cpu_ce) begin
`ifdef OAM_DMA_ALIGN_EN
      parity_d = ~parity_q;
`endif
      case (state_q)
        ST_IDLE: begin
          if (is_trig_write(i_bus_wn, i_bus_addr, TRIG_ADDR)) begin
            page_d  = i_bus_wdata;
            idx_d   = '0;
            state_d = ST_HALT;
            halt_d  = 1'b1;
            own_d   = 1'b1;
            addr_d  = '0;
            wn_d    = BUS_WN_READ;
          end
        end
        ST_HALT: begin
          state_d = ST_READ;
          addr_d  = {page_q, idx_q};
`ifdef OAM_DMA_ALIGN_EN
          // parity_d is the parity after this tick; high means the trigger
          // write landed on an odd cycle and one more dummy cycle is needed.
          if (parity_d) begin
            state_d = ST_ALIGN;
            addr_d  = '0;
          end
`endif
        end
        ST_ALIGN: begin
          state_d = ST_READ;
          addr_d  = {page_q, idx_q};
        end
        ST_READ: begin
          latch_d = i_bus_rdata;
          state_d = ST_WRITE;
          addr_d  = OAMDATA;
          wn_d    = BUS_WN_WRITE;
        end
        ST_WRITE: begin
          wn_d = BUS_WN_READ;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            halt_d  = 1'b0;
            own_d   = 1'b0;
            addr_d  = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_READ;
            addr_d  = {page_q, idx_q + 1'b1};
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          halt_d  = 1'b0;
          own_d   = 1'b0;
          addr_d  = '0;
          wn_d    = BUS_WN_READ;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= ST_IDLE;
      page_q   <= '0;
      idx_q    <= '0;
      latch_q  <= '0;
      halt_q   <= 1'b0;
      own_q    <= 1'b0;
      addr_q   <= '0;
      wn_q     <= BUS_WN_READ;
`ifdef OAM_DMA_ALIGN_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      latch_q  <= latch_d;
      halt_q   <= halt_d;
      own_q    <= own_d;
      addr_q   <= addr_d;
      wn_q     <= wn_d;
`ifdef OAM_DMA_ALIGN_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign o_cpu_halt  = halt_q;
  assign o_dma_own   = own_q;
  assign o_dma_addr  = addr_q;
  assign o_dma_wdata = latch_q;
  assign o_dma_wn    = wn_q;

endmodule

// File: tb/tb_oam_dma_master.sv
// Self-checking bench for oam_dma_master: transfer scenarios table plus reset,
// non-trigger and mid-transfer reset sequences. Honours OAM_DMA_ALIGN_EN.
module tb_oam_dma_master;

`ifdef OAM_DMA_ALIGN_EN
  localparam int ODD_HALT = 514;
`else
  localparam int ODD_HALT = 513;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        ce;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_wn;
  logic [7:0]  bus_rdata;
  logic        halt, own, wn;
  logic [15:0] addr;
  logic [7:0]  wdata;

  int tests = 0;
  int fails = 0;
  bit tb_par = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0] * 8'd7;
    return lo ^ a[15:8] ^ 8'h5A;
  endfunction

  // Bus mux + slave: the address on the bus is the DMA's while it owns it.
  assign bus_rdata = mem_fn(own ? addr : bus_addr);

  oam_dma_master dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_cpu_ce   (ce),
    .i_bus_addr (bus_addr),
    .i_bus_wdata(bus_wdata),
    .i_bus_wn   (bus_wn),
    .i_bus_rdata(bus_rdata),
    .o_cpu_halt (halt),
    .o_dma_own  (own),
    .o_dma_addr (addr),
    .o_dma_wdata(wdata),
    .o_dma_wn   (wn)
  );

  typedef struct {
    logic [7:0] page;
    bit         odd;
    int         period;
    bit         retrig;
    int         exp_halt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic c);
    ce = c;
    @(posedge clk);
    #1;
    if (c) tb_par = ~tb_par;
  endtask

  task automatic idle_bus();
    bus_addr  = 16'h0000;
    bus_wdata = 8'h00;
    bus_wn    = 1'b1;
  endtask

  task automatic check_idle(input string name);
    check(name, 32'({halt, own, wn, addr}), 32'({1'b0, 1'b0, 1'b1, 16'h0000}));
  endtask

  task automatic trigger(input string tag, input logic [7:0] page, input bit want_par);
    idle_bus();
    while (tb_par != want_par) step(1'b1);
    bus_addr  = 16'h4014;
    bus_wdata = page;
    bus_wn    = 1'b0;
    step(1'b1);
    idle_bus();
    check({tag, "_halt_after_trig"}, 32'({halt, own}), 32'(2'b11));
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] page, input int period,
                          input bit retrig, input int exp_halt, input int abort_at);
    int rd, wr, bad_rd, bad_wr, halt_ticks, unstable, cyc, ticks;
    bit done, c;
    logic [26:0] snap;
    rd = 0; wr = 0; bad_rd = 0; bad_wr = 0; halt_ticks = 0;
    unstable = 0; cyc = 0; ticks = 0; done = 1'b0;
    while (!done && cyc < 4000) begin
      c = ((cyc % period) == period - 1);
      if (retrig && ticks == 100 && c) begin
        bus_addr  = 16'h4014;
        bus_wdata = 8'h05;
        bus_wn    = 1'b0;
      end else begin
        idle_bus();
      end
      if (c) begin
        if (halt) halt_ticks++;
        if (own && !wn) begin
          if (abort_at >= 0 && wr == abort_at) return;
          if (addr !== 16'h2004 || wdata !== mem_fn({page, 8'(wr)})) bad_wr++;
          wr++;
        end else if (own && addr != 16'h0000) begin
          if (addr !== {page, 8'(rd)}) bad_rd++;
          rd++;
        end
        if (!own && !wn) bad_wr++;
      end
      snap = {halt, own, addr, wdata, wn};
      step(c);
      cyc++;
      if (c) ticks++;
      if (!c && {halt, own, addr, wdata, wn} !== snap) unstable++;
      if (ticks > 0 && !halt && !own) done = 1'b1;
    end
    idle_bus();
    check({tag, "_finished"}, 32'(done), 32'd1);
    check({tag, "_reads"}, 32'(rd), 32'd256);
    check({tag, "_writes"}, 32'(wr), 32'd256);
    check({tag, "_bad_read_addr"}, 32'(bad_rd), 32'd0);
    check({tag, "_bad_write"}, 32'(bad_wr), 32'd0);
    check({tag, "_halt_ticks"}, 32'(halt_ticks), 32'(exp_halt));
    check({tag, "_unstable"}, 32'(unstable), 32'd0);
    step(1'b1);
    step(1'b1);
    check_idle({tag, "_idle_after"});
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{page: 8'h02, odd: 1'b0, period: 1, retrig: 1'b0, exp_halt: 513};
    tbl[1] = '{page: 8'h02, odd: 1'b1, period: 1, retrig: 1'b0, exp_halt: ODD_HALT};
    tbl[2] = '{page: 8'h10, odd: 1'b0, period: 3, retrig: 1'b0, exp_halt: 513};
    tbl[3] = '{page: 8'h02, odd: 1'b0, period: 1, retrig: 1'b1, exp_halt: 513};
    tbl[4] = '{page: 8'h3F, odd: 1'b1, period: 3, retrig: 1'b0, exp_halt: ODD_HALT};

    rstn = 1'b0;
    ce   = 1'b0;
    idle_bus();
    step(1'b0);
    check_idle("rst_hold");
    check("rst_wdata", 32'(wdata), 32'd0);
    step(1'b0);
    rstn   = 1'b1;
    tb_par = 1'b0;
    step(1'b0);
    check_idle("rst_release");

    // Accesses that must not start a transfer
    bus_addr = 16'h4014; bus_wdata = 8'h02; bus_wn = 1'b1;
    step(1'b1);
    check("no_trig_read", 32'({halt, own}), 32'd0);
    bus_wn = 1'b0;
    step(1'b0);
    check("no_trig_ce_low", 32'({halt, own}), 32'd0);
    bus_addr = 16'h4015;
    step(1'b1);
    check("no_trig_other_addr", 32'({halt, own}), 32'd0);
    idle_bus();

    for (int i = 0; i < 5; i++) begin
      trigger($sformatf("v%0d", i), tbl[i].page, tbl[i].odd);
      run_xfer($sformatf("v%0d", i), tbl[i].page, tbl[i].period,
               tbl[i].retrig, tbl[i].exp_halt, -1);
    end

    // Reset while writing index $80, then a clean transfer from $0300
    trigger("abort", 8'h02, 1'b0);
    run_xfer("abort", 8'h02, 1, 1'b0, 513, 128);
    check("abort_in_write", 32'({own, wn, addr}), 32'({1'b1, 1'b0, 16'h2004}));
    rstn = 1'b0;
    #1;
    check_idle("abort_rst_outs");
    step(1'b0);
    rstn   = 1'b1;
    tb_par = 1'b0;
    step(1'b0);
    check_idle("abort_released");
    trigger("after_abort", 8'h03, 1'b0);
    run_xfer("after_abort", 8'h03, 1, 1'b0, 513, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
